// File: rtl/mul_operand_loader.sv
// Operand loader for the multiplier: nibble-wise switch entry on key presses, start/done handshake, product capture.
// Optional macro LOADER_DEBOUNCE_EN inserts a counter debouncer between key synchronizer and edge detector.
module mul_operand_loader #(
   parameter  int NIBBLES         = 8,
   parameter  int SYNC_STAGES     = 2,
   parameter  int DEBOUNCE_CYCLES = 50000,
   localparam int OP_W            = 4 * NIBBLES
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        nib_in,
   input  logic              key_enter,
   input  logic              key_go,
   input  logic              mul_done,
   input  logic [2*OP_W-1:0] mul_product,
   output logic              mul_start,
   output logic [OP_W-1:0]   mul_a,
   output logic [OP_W-1:0]   mul_b,
   output logic [2*OP_W-1:0] result,
   output logic              result_valid,
   output logic              busy,
   output logic [4:0]        digit_cnt,
   output logic              sel_b
);

   typedef enum logic [1:0] {ENTRY, START, WAIT, DONE} state_t;

   localparam logic [4:0] NIB_CNT  = 5'(NIBBLES);
   localparam logic [4:0] FULL_CNT = 5'(2 * NIBBLES);

   if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
      $error("mul_operand_loader: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
   end

   state_t                          state;
   logic [1:0]                      key_raw;
   logic [1:0][SYNC_STAGES-1:0]     sync_q;
   logic [1:0]                      sync_lvl;
   logic [1:0]                      key_lvl;
   logic [1:0]                      prev_q;
   logic                            enter_ev;
   logic                            go_ev;

   assign key_raw = {key_go, key_enter};

   // NOTE: every clocked register here uses <= so all flops sample pre-edge values;
   // a blocking = would let one stage see the next stage's new value in the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            sync_q[k] <= {sync_q[k][SYNC_STAGES-2:0], key_raw[k]};
         end
      end
   end

   always_comb begin
      sync_lvl[0] = sync_q[0][SYNC_STAGES-1];
      sync_lvl[1] = sync_q[1][SYNC_STAGES-1];
   end

`ifdef LOADER_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [1:0]            level_q;
   logic [1:0][CNT_W-1:0] cnt_q;

   // Accepted level flips only after the synchronized input disagrees for DEBOUNCE_CYCLES in a row.
   always_ff @(posedge clk) begin
      if (reset) begin
         level_q <= '0;
         cnt_q   <= '0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (sync_lvl[k] != level_q[k]) begin
               if (cnt_q[k] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                  level_q[k] <= sync_lvl[k];
                  cnt_q[k]   <= '0;
               end else begin
                  cnt_q[k] <= cnt_q[k] + 1'b1;
               end
            end else begin
               cnt_q[k] <= '0;
            end
         end
      end
   end

   assign key_lvl = level_q;
`else
   assign key_lvl = sync_lvl;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q <= '0;
      end else begin
         prev_q <= key_lvl;
      end
   end

   assign enter_ev = key_lvl[0] & ~prev_q[0];
   assign go_ev    = key_lvl[1] & ~prev_q[1];
   assign sel_b    = (digit_cnt >= NIB_CNT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ENTRY;
         mul_a        <= '0;
         mul_b        <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         mul_start    <= 1'b0;
         busy         <= 1'b0;
         digit_cnt    <= '0;
      end else begin
         mul_start <= 1'b0;
         case (state)
            ENTRY: begin
               // Go outranks a simultaneous enter only once both operands are complete.
               if (go_ev && digit_cnt == FULL_CNT) begin
                  state     <= START;
                  mul_start <= 1'b1;
                  busy      <= 1'b1;
               end else if (enter_ev && digit_cnt < FULL_CNT) begin
                  if (!sel_b) begin
                     mul_a <= {mul_a[OP_W-5:0], nib_in};
                  end else begin
                     mul_b <= {mul_b[OP_W-5:0], nib_in};
                  end
                  digit_cnt <= digit_cnt + 5'd1;
               end
            end
            START: begin
               result_valid <= 1'b0;
               state        <= WAIT;
            end
            WAIT: begin
               if (mul_done) begin
                  result       <= mul_product;
                  result_valid <= 1'b1;
                  busy         <= 1'b0;
                  state        <= DONE;
               end
            end
            DONE: begin
               if (go_ev) begin
                  state     <= START;
                  mul_start <= 1'b1;
                  busy      <= 1'b1;
               end else if (enter_ev) begin
                  mul_a     <= OP_W'(nib_in);
                  mul_b     <= '0;
                  digit_cnt <= 5'd1;
                  state     <= ENTRY;
               end
            end
            default: state <= ENTRY;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_operand_loader.sv
// Directed bench for mul_operand_loader: entry, start/done handshake, saturation, priority, reset-in-WAIT,
// and (with LOADER_DEBOUNCE_EN) bounce rejection.
module tb_mul_operand_loader;

   localparam int NIBBLES         = 8;
   localparam int OP_W            = 4 * NIBBLES;
   localparam int SYNC_STAGES     = 2;
   localparam int DEBOUNCE_CYCLES = 4;
`ifdef LOADER_DEBOUNCE_EN
   localparam int HOLD   = 8;
   localparam int SETTLE = 12;
`else
   localparam int HOLD   = 1;
   localparam int SETTLE = 6;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic [3:0]        nib_in;
   logic              key_enter;
   logic              key_go;
   logic              mul_done;
   logic [2*OP_W-1:0] mul_product;
   logic              mul_start;
   logic [OP_W-1:0]   mul_a;
   logic [OP_W-1:0]   mul_b;
   logic [2*OP_W-1:0] result;
   logic              result_valid;
   logic              busy;
   logic [4:0]        digit_cnt;
   logic              sel_b;

   int vectors     = 0;
   int miscompares = 0;

   mul_operand_loader #(
      .NIBBLES         (NIBBLES),
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .nib_in       (nib_in),
      .key_enter    (key_enter),
      .key_go       (key_go),
      .mul_done     (mul_done),
      .mul_product  (mul_product),
      .mul_start    (mul_start),
      .mul_a        (mul_a),
      .mul_b        (mul_b),
      .result       (result),
      .result_valid (result_valid),
      .busy         (busy),
      .digit_cnt    (digit_cnt),
      .sel_b        (sel_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Starts at a negedge; holds the keys HOLD cycles, then lets the key path settle.
   // Reports how many sampled cycles showed mul_start and the busy level seen with it.
   task automatic press(input logic [3:0] nib, input logic en, input logic go,
                        output int starts, output logic busy_at_start);
      starts        = 0;
      busy_at_start = 1'b0;
      nib_in        = nib;
      key_enter     = en;
      key_go        = go;
      for (int i = 0; i < HOLD + SETTLE; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (mul_start) begin
            starts++;
            busy_at_start = busy;
         end
         if (i == HOLD - 1) begin
            key_enter = 1'b0;
            key_go    = 1'b0;
         end
      end
   endtask

   task automatic pulse_done(input logic [2*OP_W-1:0] prod);
      mul_done    = 1'b1;
      mul_product = prod;
      @(negedge clk);
      mul_done    = 1'b0;
      mul_product = 64'hDEAD_BEEF_DEAD_BEEF;
   endtask

   initial begin
      logic [63:0] digits;
      int          st;
      logic        bz;

      reset       = 1'b1;
      nib_in      = 4'h0;
      key_enter   = 1'b0;
      key_go      = 1'b0;
      mul_done    = 1'b0;
      mul_product = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      check("rst_mul_a", mul_a, 0);
      check("rst_mul_b", mul_b, 0);
      check("rst_result", result, 0);
      check("rst_valid", result_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_start", mul_start, 0);
      check("rst_cnt", digit_cnt, 0);
      check("rst_sel_b", sel_b, 0);

      // Sixteen presses: A = 12345678, B = 00000003, MSB first.
      digits = 64'h1234_5678_0000_0003;
      for (int i = 0; i < 16; i++) begin
         press(digits[63-4*i -: 4], 1'b1, 1'b0, st, bz);
         if (i == 7) begin
            check("half_cnt", digit_cnt, 8);
            check("half_sel_b", sel_b, 1);
            check("half_mul_a", mul_a, 32'h1234_5678);
            check("half_mul_b", mul_b, 0);
         end
      end
      check("full_mul_a", mul_a, 32'h1234_5678);
      check("full_mul_b", mul_b, 32'h0000_0003);
      check("full_cnt", digit_cnt, 16);
      check("full_sel_b", sel_b, 1);

      press(4'h9, 1'b1, 1'b0, st, bz);
      check("sat_mul_b", mul_b, 32'h0000_0003);
      check("sat_cnt", digit_cnt, 16);

      // Go with full operands: one start pulse, then WAIT.
      press(4'h0, 1'b0, 1'b1, st, bz);
      check("go_start_cycles", st, 1);
      check("go_busy_at_start", bz, 1);
      check("wait_busy", busy, 1);
      check("wait_start_low", mul_start, 0);
      check("wait_mul_a", mul_a, 32'h1234_5678);
      repeat (2) @(negedge clk);
      pulse_done(64'h0000_0000_369D_0368);
      check("done_result", result, 64'h0000_0000_369D_0368);
      check("done_valid", result_valid, 1);
      check("done_busy", busy, 0);

      // A done outside WAIT must not touch the result.
      pulse_done(64'h1111_2222_3333_4444);
      check("stray_done_result", result, 64'h0000_0000_369D_0368);

      // Re-run from DONE with the same operands; START drops result_valid.
      press(4'h0, 1'b0, 1'b1, st, bz);
      check("rerun_start_cycles", st, 1);
      check("rerun_valid_cleared", result_valid, 0);
      check("rerun_mul_b", mul_b, 32'h0000_0003);
      pulse_done(64'hFFFF_FFFF_0000_0001);
      check("rerun_result", result, 64'hFFFF_FFFF_0000_0001);
      check("rerun_valid", result_valid, 1);

      // Enter in DONE restarts entry with this nibble already in A.
      press(4'h5, 1'b1, 1'b0, st, bz);
      check("restart_mul_a", mul_a, 32'h0000_0005);
      check("restart_mul_b", mul_b, 0);
      check("restart_cnt", digit_cnt, 1);
      check("restart_valid_held", result_valid, 1);
      press(4'h6, 1'b1, 1'b0, st, bz);
      press(4'h7, 1'b1, 1'b0, st, bz);

      // Enter+go together at count 3: enter wins.
      press(4'h8, 1'b1, 1'b1, st, bz);
      check("both_cnt3_start", st, 0);
      check("both_cnt3_mul_a", mul_a, 32'h0000_5678);
      check("both_cnt3_cnt", digit_cnt, 4);

      digits = 64'h0000_0000_0009_ABCD;
      for (int i = 11; i < 16; i++) press(digits[63-4*i -: 4], 1'b1, 1'b0, st, bz);
      check("cnt9_mul_a", mul_a, 32'h5678_9ABC);
      check("cnt9_mul_b", mul_b, 32'h0000_000D);
      press(4'h0, 1'b0, 1'b1, st, bz);
      check("go_cnt9_start", st, 0);
      check("go_cnt9_cnt", digit_cnt, 9);

      digits = 64'h0000_0000_0EF0_1234;
      for (int i = 9; i < 16; i++) press(digits[63-4*i -: 4], 1'b1, 1'b0, st, bz);
      check("full2_mul_b", mul_b, 32'hDEF0_1234);
      check("full2_cnt", digit_cnt, 16);

      // Enter+go together at count 16: go wins, operands untouched.
      press(4'h1, 1'b1, 1'b1, st, bz);
      check("both_cnt16_start", st, 1);
      check("both_cnt16_mul_a", mul_a, 32'h5678_9ABC);
      check("both_cnt16_mul_b", mul_b, 32'hDEF0_1234);
      check("both_cnt16_busy", busy, 1);

      // Reset in WAIT, then a late done.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      pulse_done(64'h0123_4567_89AB_CDEF);
      check("wrst_result", result, 0);
      check("wrst_valid", result_valid, 0);
      check("wrst_cnt", digit_cnt, 0);
      check("wrst_busy", busy, 0);
      check("wrst_mul_a", mul_a, 0);
      repeat (2) @(negedge clk);
      check("wrst_no_start", mul_start, 0);

`ifdef LOADER_DEBOUNCE_EN
      nib_in = 4'hA;
      digits = 64'h0000_0000_0000_000A;
      for (int i = 0; i < 4; i++) begin
         key_enter = digits[i];
         @(negedge clk);
      end
      key_enter = 1'b1;
      repeat (10) @(negedge clk);
      key_enter = 1'b0;
      repeat (12) @(negedge clk);
      check("db_bounce_cnt", digit_cnt, 1);
      check("db_bounce_mul_a", mul_a, 32'h0000_000A);
      key_enter = 1'b1;
      repeat (3) @(negedge clk);
      key_enter = 1'b0;
      repeat (12) @(negedge clk);
      check("db_glitch_cnt", digit_cnt, 1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
